mem_loader: RTL and testbench

//  Write-phase responder for the top-level mode controller. While `write` is high, accepts a byte

---
 rtl/mem_loader_pkg.sv | 24 ++
 rtl/mem_loader_if.sv | 38 +++
 rtl/mem_loader_byte_packer.sv | 53 +++++
 rtl/mem_loader.sv | 179 +++++++++++++++++
 tb/tb_mem_loader.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared types and constants for the memory image loader.
//   loader_state_t : FSM state encoding used by mem_loader
//   BYTE_W         : width of one stream byte
//   sum8()         : modulo-256 running checksum step
package mem_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    COMMIT,
    CHECK,
    DONE,
    ERR
  } loader_state_t;

  // Byte-wide add; the carry out is dropped on purpose (sum mod 256).
  function automatic logic [BYTE_W-1:0] sum8(input logic [BYTE_W-1:0] acc,
                                             input logic [BYTE_W-1:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/mem_loader_if.sv
// mem_loader_if: byte-stream input, memory write port and phase status of the loader.
//   write      : load phase requested (controller -> loader)
//   in_valid   : byte available (source -> loader)
//   in_data    : byte value (source -> loader)
//   in_ready   : loader takes the byte this cycle (loader -> source)
//   mem_we     : one-cycle memory write strobe (loader -> memory)
//   mem_addr   : memory write address (loader -> memory)
//   mem_wdata  : memory write data (loader -> memory)
//   write_done : image complete (loader -> controller)
//   chk_err    : checksum mismatch (loader -> controller)
// Modports: master = controller/source/memory side, slave = loader.
interface mem_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  import mem_loader_pkg::*;

  logic              write;
  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              write_done;
  logic              chk_err;

  modport master (
    output write, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, write_done, chk_err
  );

  modport slave (
    input  write, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, write_done, chk_err
  );

endinterface

// File: rtl/mem_loader_byte_packer.sv
// mem_loader_byte_packer: assembles bytes little-endian into a DATA_W word.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : restart at byte 0 and clear the word
//   push     : store byte_in at the current byte slot and advance
//   byte_in  : incoming byte
//   word_out : registered assembled word
//   last     : current slot is the final byte of the word
module mem_loader_byte_packer
  import mem_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [DATA_W-1:0] word_out,
  output logic              last
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic [DATA_W-1:0] word_q, word_d;

  assign last     = (byte_idx_q == IDX_W'(NB - 1));
  assign word_out = word_q;

  always_comb begin
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    if (clr) begin
      byte_idx_d = '0;
      word_d     = '0;
    end else if (push) begin
      word_d[BYTE_W*byte_idx_q +: BYTE_W] = byte_in;
      byte_idx_d = last ? '0 : byte_idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx_q <= '0;
      word_q     <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// mem_loader: write-phase responder. While bus.write is high, accepts a byte
// stream, packs it little-endian into DATA_W words and writes NUM_WORDS words
// starting at BASE_ADDR, then holds write_done until write drops.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mem_loader_if.slave (byte stream in, memory write port out, status)
// Optional feature: define MEM_LOADER_CHECKSUM_EN to expect one trailing
// checksum byte (sum of data bytes mod 256) after the image; a mismatch
// raises chk_err instead of write_done.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int NUM_WORDS = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        rst,
  mem_loader_if.slave bus
);

  localparam int CNT_W = ADDR_W + 1;

  loader_state_t     state_q, state_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic              write_done_q, write_done_d;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] checksum_q, checksum_d;
  logic              chk_err_q, chk_err_d;
`endif

  logic              accept;
  logic              pk_clr;
  logic              pk_push;
  logic              pk_last;
  logic [DATA_W-1:0] pk_word;

  mem_loader_byte_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (pk_clr),
    .push     (pk_push),
    .byte_in  (bus.in_data),
    .word_out (pk_word),
    .last     (pk_last)
  );

  // Strobes are gated by write so a dropped request neither takes a byte
  // from the source nor lets an in-flight COMMIT reach memory.
  assign bus.in_ready   = in_ready_q & bus.write;
  assign bus.mem_we     = mem_we_q & bus.write;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = pk_word;
  assign bus.write_done = write_done_q;
`ifdef MEM_LOADER_CHECKSUM_EN
  assign bus.chk_err    = chk_err_q;
`else
  assign bus.chk_err    = 1'b0;
`endif

  assign accept = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    mem_addr_d = mem_addr_q;
    pk_clr     = 1'b0;
    pk_push    = 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
    checksum_d = checksum_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.write) begin
          pk_clr     = 1'b1;
          word_cnt_d = '0;
`ifdef MEM_LOADER_CHECKSUM_EN
          checksum_d = '0;
`endif
          state_d    = RECV;
        end
      end

      RECV: begin
        if (!bus.write) begin
          state_d = IDLE;
        end else if (accept) begin
          pk_push = 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
          checksum_d = sum8(checksum_q, bus.in_data);
`endif
          if (pk_last) begin
            // Address is loaded here so it is already stable during COMMIT.
            mem_addr_d = ADDR_W'(BASE_ADDR) + word_cnt_q[ADDR_W-1:0];
            state_d    = COMMIT;
          end
        end
      end

      COMMIT: begin
        if (!bus.write) begin
          state_d = IDLE;
        end else begin
          word_cnt_d = word_cnt_q + CNT_W'(1);
          if (word_cnt_q == CNT_W'(NUM_WORDS - 1)) begin
`ifdef MEM_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = RECV;
          end
        end
      end

`ifdef MEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (!bus.write) begin
          state_d = IDLE;
        end else if (accept) begin
          state_d = (bus.in_data == checksum_q) ? DONE : ERR;
        end
      end

      ERR: begin
        if (!bus.write) state_d = IDLE;
      end
`endif

      DONE: begin
        if (!bus.write) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    in_ready_d   = (state_d == RECV) || (state_d == CHECK);
    mem_we_d     = (state_d == COMMIT);
    write_done_d = (state_d == DONE);
`ifdef MEM_LOADER_CHECKSUM_EN
    chk_err_d    = (state_d == ERR);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      mem_addr_q   <= ADDR_W'(BASE_ADDR);
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      write_done_q <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
      checksum_q   <= '0;
      chk_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      mem_addr_q   <= mem_addr_d;
      in_ready_q   <= in_ready_d;
      mem_we_q     <= mem_we_d;
      write_done_q <= write_done_d;
`ifdef MEM_LOADER_CHECKSUM_EN
      checksum_q   <= checksum_d;
      chk_err_q    <= chk_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: scoreboard bench for mem_loader. Two loaders (BASE_ADDR 0 and
// 0x3FE, NUM_WORDS 2 each) share one byte stream; expected memory writes are
// queued by the stimulus and popped by per-DUT monitors on every mem_we.
// Honours MEM_LOADER_CHECKSUM_EN when it is defined for the build.
module tb_mem_loader;
  import mem_loader_pkg::*;

  localparam int A_BASE = 0;
  localparam int B_BASE = 'h3FE;
  localparam int NW     = 2;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       write;
  logic       in_valid;
  logic [7:0] in_data;

  int n_checks = 0;
  int n_pass   = 0;

  wr_t exp_a[$];
  wr_t exp_b[$];
  wr_t ea, eb;

  always #5 clk = ~clk;

  mem_loader_if #(.DATA_W(32), .ADDR_W(10)) bus_a ();
  mem_loader_if #(.DATA_W(32), .ADDR_W(10)) bus_b ();

  assign bus_a.write    = write;
  assign bus_a.in_valid = in_valid;
  assign bus_a.in_data  = in_data;
  assign bus_b.write    = write;
  assign bus_b.in_valid = in_valid;
  assign bus_b.in_data  = in_data;

  mem_loader #(.DATA_W(32), .ADDR_W(10), .NUM_WORDS(NW), .BASE_ADDR(A_BASE)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a.slave)
  );
  mem_loader #(.DATA_W(32), .ADDR_W(10), .NUM_WORDS(NW), .BASE_ADDR(B_BASE)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b.slave)
  );

  initial begin
    assert (B_BASE + NW <= 1024) else $error("dut_b address range wraps past 2**ADDR_W");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitors: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus_a.mem_we) begin
      if (exp_a.size() == 0) chk("unexpected_write_a", 64'(exp_a.size()), 64'd1);
      else begin
        ea = exp_a.pop_front();
        chk("wr_addr_a", bus_a.mem_addr, ea.addr);
        chk("wr_data_a", bus_a.mem_wdata, ea.data);
      end
      chk("rdy_in_commit_a", bus_a.in_ready, 0);
      chk("done_in_commit_a", bus_a.write_done, 0);
    end
    if (bus_a.write_done) chk("rdy_in_done_a", bus_a.in_ready, 0);
  end

  always @(negedge clk) begin
    if (bus_b.mem_we) begin
      if (exp_b.size() == 0) chk("unexpected_write_b", 64'(exp_b.size()), 64'd1);
      else begin
        eb = exp_b.pop_front();
        chk("wr_addr_b", bus_b.mem_addr, eb.addr);
        chk("wr_data_b", bus_b.mem_wdata, eb.data);
      end
      chk("rdy_in_commit_b", bus_b.in_ready, 0);
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"},   bus_a.in_ready, 0);
    chk({tag, "_mem_we"},     bus_a.mem_we, 0);
    chk({tag, "_write_done"}, bus_a.write_done, 0);
    chk({tag, "_chk_err"},    bus_a.chk_err, 0);
    chk({tag, "_mem_addr_a"}, bus_a.mem_addr, 10'h000);
    chk({tag, "_mem_wdata"},  bus_a.mem_wdata, 32'h0);
    chk({tag, "_mem_addr_b"}, bus_b.mem_addr, 10'h3FE);
    chk({tag, "_mem_we_b"},   bus_b.mem_we, 0);
  endtask

  task automatic expect_word(input logic [9:0] idx, input logic [31:0] data);
    exp_a.push_back('{addr: 10'(A_BASE) + idx, data: data});
    exp_b.push_back('{addr: 10'(B_BASE) + idx, data: data});
  endtask

  // Raise write and check that in_ready appears exactly one cycle later.
  task automatic start_write();
    @(posedge clk); #1;
    write = 1'b1;
    @(negedge clk);
    chk("rdy_latency0", bus_a.in_ready, 0);
    @(negedge clk);
    chk("rdy_latency1", bus_a.in_ready, 1);
    @(posedge clk); #1;
  endtask

  // Offer one byte until it is taken (bounded), then idle for gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (bus_a.in_ready) got = 1'b1;
    end
    chk("byte_accepted", 64'(got), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && !bus_a.write_done; i++) @(negedge clk);
    chk("write_done_a", bus_a.write_done, 1);
    chk("write_done_b", bus_b.write_done, 1);
    chk("chk_err_clear", bus_a.chk_err, 0);
  endtask

  task automatic end_write();
    @(posedge clk); #1;
    write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("done_after_drop", bus_a.write_done, 0);
    chk("rdy_after_drop", bus_a.in_ready, 0);
  endtask

  // Full image: bytes b0..b0+7, words w0/w1, optional trailing checksum cks.
  task automatic run_image(input logic [7:0] b0, input logic [31:0] w0,
                           input logic [31:0] w1, input int gap, input logic [7:0] cks);
    expect_word(10'd0, w0);
    expect_word(10'd1, w1);
    start_write();
    for (int i = 0; i < 8; i++) send_byte(b0 + 8'(i), gap);
`ifdef MEM_LOADER_CHECKSUM_EN
    send_byte(cks, 0);
`else
    $display("info: image from 0x%02h loaded, checksum byte 0x%02h not used", b0, cks);
`endif
    wait_done();
    repeat (3) begin
      @(negedge clk);
      chk("done_held", bus_a.write_done, 1);
    end
    chk("queue_a_drained", 64'(exp_a.size()), 0);
    chk("queue_b_drained", 64'(exp_b.size()), 0);
    // A source that keeps offering data in DONE must not be served.
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    repeat (3) begin
      @(negedge clk);
      chk("rdy_ignored_done", bus_a.in_ready, 0);
    end
    in_valid = 1'b0;
    end_write();
  endtask

  initial begin
    rst      = 1'b1;
    write    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Byte offered while idle is left with the source.
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rdy_ignored_idle", bus_a.in_ready, 0);
    end
    in_valid = 1'b0;

    // Back-to-back image, then with in_valid toggling.
    run_image(8'h01, 32'h04030201, 32'h08070605, 0, 8'h24);
    run_image(8'h01, 32'h04030201, 32'h08070605, 1, 8'h24);

    // Abort after 5 bytes: only word 0 reaches memory.
    expect_word(10'd0, 32'h04030201);
    start_write();
    for (int i = 0; i < 5; i++) send_byte(8'h01 + 8'(i), 0);
    write = 1'b0;
    @(negedge clk);
    chk("rdy_gated_abort", bus_a.in_ready, 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", bus_a.write_done, 0);
    chk("abort_queue_a", 64'(exp_a.size()), 0);

    // Abort during COMMIT: the gated strobe must write nothing.
    start_write();
    for (int i = 0; i < 4; i++) send_byte(8'h31 + 8'(i), 0);
    write = 1'b0;
    @(negedge clk);
    chk("we_gated_abort", bus_a.mem_we, 0);
    repeat (3) @(negedge clk);

    // Re-arm reloads from word 0.
    run_image(8'h11, 32'h14131211, 32'h18171615, 0, 8'hA4);

    // Asynchronous reset in the middle of COMMIT.
    expect_word(10'd0, 32'h24232221);
    start_write();
    for (int i = 0; i < 4; i++) send_byte(8'h21 + 8'(i), 0);
    @(negedge clk);
    chk("we_before_rst", bus_a.mem_we, 1);
    #2;
    rst   = 1'b1;
    write = 1'b0;
    #1;
    check_reset("async_rst");
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset("post_rst");
    chk("rst_queue_a", 64'(exp_a.size()), 0);

`ifdef MEM_LOADER_CHECKSUM_EN
    // Wrong checksum byte: ERR until write drops.
    expect_word(10'd0, 32'h04030201);
    expect_word(10'd1, 32'h08070605);
    start_write();
    for (int i = 0; i < 8; i++) send_byte(8'h01 + 8'(i), 0);
    send_byte(8'h25, 0);
    repeat (3) begin
      @(negedge clk);
      chk("err_chk_err", bus_a.chk_err, 1);
      chk("err_no_done", bus_a.write_done, 0);
    end
    @(posedge clk); #1;
    write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("err_cleared", bus_a.chk_err, 0);
`endif

    repeat (2) @(negedge clk);
    chk("final_queue_a", 64'(exp_a.size()), 0);
    chk("final_queue_b", 64'(exp_b.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so a stuck run still reports.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
